rr_burst_sched: RTL and testbench

Stateful round-robin scheduler that shares one downstream valid/ready port among REQ_NUM requesters, each sending multi-beat packets. It holds the rotating priority pointer, locks the grant for a whole packet (until the beat flagged `last`), and multiplexes the winner's data onto the shared port. It sits between the requester queues and the shared ROB write/issue resource.

---
 rtl/rr_burst_sched_if.sv | 27 ++
 rtl/rr_burst_sched.sv | 97 +++++++++
 tb/tb_rr_burst_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rr_burst_sched_if.sv
// Requester-side and shared-port signals of the round-robin burst scheduler.
// The master modport is the requester/downstream side; the slave modport is the scheduler.
interface rr_burst_sched_if #(
  parameter int unsigned REQ_NUM       = 4,
  parameter int unsigned REQ_NUM_WIDTH = 2,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic [REQ_NUM-1:0]            req_valid;
  logic [REQ_NUM-1:0]            req_last;
  logic [REQ_NUM*DATA_WIDTH-1:0] req_data;
  logic [REQ_NUM-1:0]            req_ready;
  logic                          out_valid;
  logic                          out_last;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [REQ_NUM_WIDTH-1:0]      out_id;
  logic                          out_ready;

  modport master (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, out_valid, out_last, out_data, out_id
  );

  modport slave (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, out_valid, out_last, out_data, out_id
  );
endinterface

// File: rtl/rr_burst_sched.sv
// Round-robin scheduler sharing one valid/ready port among REQ_NUM packet sources.
// The grant is locked from arbitration until the accepted beat flagged last.
module rr_burst_sched #(
  parameter int unsigned REQ_NUM       = 4,
  parameter int unsigned REQ_NUM_WIDTH = 2,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  rr_burst_sched_if.slave          bus,
  output logic                     busy,
  output logic [REQ_NUM_WIDTH-1:0] priority_pnt
);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e                   state_q, state_d;
  logic [REQ_NUM_WIDTH-1:0] pnt_q, pnt_d;
  logic [REQ_NUM_WIDTH-1:0] id_q, id_d;

  logic [REQ_NUM_WIDTH-1:0] win;
  logic                     found;
  int unsigned              idx;
  logic [REQ_NUM_WIDTH-1:0] idx_w;
  logic [DATA_WIDTH-1:0]    data_arr [REQ_NUM];

  always_comb begin
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      data_arr[k] = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First valid index scanning pnt, pnt+1, ... with wrap at REQ_NUM.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_w = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      idx = 32'(pnt_q) + i;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      idx_w = REQ_NUM_WIDTH'(idx);
      if (!found && bus.req_valid[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    pnt_d         = pnt_q;
    id_d          = id_q;
    bus.req_ready = '0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          id_d    = win;
          state_d = StLock;
        end
      end
      StLock: begin
        bus.out_valid       = bus.req_valid[id_q];
        bus.out_last        = bus.req_last[id_q];
        bus.out_data        = data_arr[id_q];
        bus.req_ready[id_q] = bus.out_ready;
        if (bus.req_valid[id_q] && bus.out_ready && bus.req_last[id_q]) begin
          state_d = StIdle;
          // Explicit wrap so non-power-of-2 REQ_NUM never reaches an unused index.
          if (32'(id_q) == REQ_NUM - 1) pnt_d = '0;
          else                          pnt_d = id_q + REQ_NUM_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pnt_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      pnt_q   <= pnt_d;
      id_q    <= id_d;
    end
  end

  assign busy         = (state_q == StLock);
  assign priority_pnt = pnt_q;
  assign bus.out_id   = id_q;

endmodule

// File: tb/tb_rr_burst_sched.sv
// Directed bench for rr_burst_sched: a 4-requester instance plus a 3-requester one for wrap.
module tb_rr_burst_sched;
  logic clk = 1'b0;
  logic rst;
  logic       busy4, busy3;
  logic [1:0] pnt4, pnt3;
  int checks = 0;
  int errors = 0;

  rr_burst_sched_if #(.REQ_NUM(4), .REQ_NUM_WIDTH(2), .DATA_WIDTH(32)) bus4 ();
  rr_burst_sched_if #(.REQ_NUM(3), .REQ_NUM_WIDTH(2), .DATA_WIDTH(32)) bus3 ();

  rr_burst_sched #(.REQ_NUM(4), .REQ_NUM_WIDTH(2), .DATA_WIDTH(32)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave), .busy(busy4), .priority_pnt(pnt4)
  );
  rr_burst_sched #(.REQ_NUM(3), .REQ_NUM_WIDTH(2), .DATA_WIDTH(32)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave), .busy(busy3), .priority_pnt(pnt3)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and leave a margin before driving new inputs.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus4.req_valid = '0; bus4.req_last = '0; bus4.req_data = '0; bus4.out_ready = 1'b0;
    bus3.req_valid = '0; bus3.req_last = '0; bus3.req_data = '0; bus3.out_ready = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus4.req_valid = 4'hF; bus4.req_last = 4'hF; bus4.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc(); #1;
      checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus4.out_valid); end
      checks++; if (bus4.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", bus4.req_ready); end
      checks++; if (pnt4 !== 2'd0) begin errors++; $display("FAIL reset_pnt got %0d exp 0", pnt4); end
    end
    rst = 1'b0;
    #1;
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy4); end
    checks++; if (bus4.out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %h exp 0", bus4.out_data); end
    cyc(); #1;
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL reset_then_busy got %b exp 1", busy4); end
    checks++; if (bus4.out_id !== 2'd0) begin errors++; $display("FAIL reset_then_id got %0d exp 0", bus4.out_id); end
  endtask

  task automatic test_rotation();
    logic [1:0] g;
    apply_reset();
    bus4.req_valid = 4'hF; bus4.req_last = 4'hF; bus4.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) bus4.req_data[k*32 +: 32] = 32'hA0 + k;
    for (int i = 0; i < 5; i++) begin
      g = 2'(i % 4);
      cyc(); #1;
      checks++; if (bus4.out_id !== g) begin errors++; $display("FAIL rot_id got %0d exp %0d", bus4.out_id, g); end
      checks++; if (bus4.req_ready !== (4'b0001 << g)) begin errors++; $display("FAIL rot_ready got %b exp %b", bus4.req_ready, 4'b0001 << g); end
      checks++; if (bus4.out_data !== 32'hA0 + 32'(g)) begin errors++; $display("FAIL rot_data got %h exp %h", bus4.out_data, 32'hA0 + 32'(g)); end
      cyc(); #1;
      checks++; if (bus4.out_valid !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL rot_bubble got valid %b busy %b exp 0 0", bus4.out_valid, busy4); end
      checks++; if (pnt4 !== g + 2'd1) begin errors++; $display("FAIL rot_pnt got %0d exp %0d", pnt4, g + 2'd1); end
    end
  endtask

  task automatic test_burst_lock();
    apply_reset();
    bus4.req_valid = 4'b0001; bus4.req_last = 4'b0001; bus4.out_ready = 1'b1;
    cyc(); cyc(); #1;
    checks++; if (pnt4 !== 2'd1) begin errors++; $display("FAIL burst_pnt_start got %0d exp 1", pnt4); end
    bus4.req_valid = 4'b0110; bus4.req_last = 4'b0010;
    cyc(); #1;
    checks++; if (bus4.out_id !== 2'd1) begin errors++; $display("FAIL burst_first_id got %0d exp 1", bus4.out_id); end
    cyc(); cyc();
    for (int b = 0; b < 4; b++) begin
      bus4.req_data[2*32 +: 32] = 32'h200 + b;
      bus4.req_last = (b == 3) ? 4'b0110 : 4'b0010;
      #1;
      checks++; if (bus4.out_id !== 2'd2 || bus4.out_valid !== 1'b1) begin errors++; $display("FAIL burst_beat_id got id %0d valid %b exp 2 1", bus4.out_id, bus4.out_valid); end
      checks++; if (bus4.out_data !== 32'h200 + 32'(b)) begin errors++; $display("FAIL burst_beat_data got %h exp %h", bus4.out_data, 32'h200 + 32'(b)); end
      checks++; if (bus4.out_last !== (b == 3)) begin errors++; $display("FAIL burst_beat_last got %b exp %b", bus4.out_last, b == 3); end
      checks++; if (bus4.req_ready !== 4'b0100) begin errors++; $display("FAIL burst_beat_ready got %b exp 0100", bus4.req_ready); end
      cyc();
    end
    #1;
    checks++; if (busy4 !== 1'b0 || pnt4 !== 2'd3) begin errors++; $display("FAIL burst_end got busy %b pnt %0d exp 0 3", busy4, pnt4); end
  endtask

  task automatic test_gap();
    apply_reset();
    bus4.req_valid = 4'b0001; bus4.req_last = 4'b0000; bus4.out_ready = 1'b1;
    bus4.req_data[0 +: 32] = 32'h300;
    cyc(); #1;
    checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 32'h300) begin errors++; $display("FAIL gap_beat1 got valid %b data %h exp 1 300", bus4.out_valid, bus4.out_data); end
    cyc();
    bus4.req_valid = 4'b1110; bus4.req_data[0 +: 32] = 32'hDEAD; #1;
    checks++; if (bus4.out_valid !== 1'b0 || busy4 !== 1'b1) begin errors++; $display("FAIL gap_cyc1 got valid %b busy %b exp 0 1", bus4.out_valid, busy4); end
    checks++; if (bus4.req_ready !== 4'b0001) begin errors++; $display("FAIL gap_cyc1_ready got %b exp 0001", bus4.req_ready); end
    cyc();
    bus4.out_ready = 1'b0; #1;
    checks++; if (bus4.out_valid !== 1'b0 || busy4 !== 1'b1) begin errors++; $display("FAIL gap_cyc2 got valid %b busy %b exp 0 1", bus4.out_valid, busy4); end
    checks++; if (bus4.req_ready !== 4'b0000) begin errors++; $display("FAIL gap_cyc2_ready got %b exp 0000", bus4.req_ready); end
    cyc();
    bus4.out_ready = 1'b1; bus4.req_valid = 4'b1111; bus4.req_last = 4'b0001;
    bus4.req_data[0 +: 32] = 32'h301; #1;
    checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 32'h301 || bus4.out_last !== 1'b1) begin errors++; $display("FAIL gap_beat2 got valid %b data %h last %b exp 1 301 1", bus4.out_valid, bus4.out_data, bus4.out_last); end
    checks++; if (bus4.out_id !== 2'd0 || bus4.req_ready !== 4'b0001) begin errors++; $display("FAIL gap_beat2_grant got id %0d ready %b exp 0 0001", bus4.out_id, bus4.req_ready); end
    cyc(); #1;
    checks++; if (busy4 !== 1'b0 || pnt4 !== 2'd1) begin errors++; $display("FAIL gap_end got busy %b pnt %0d exp 0 1", busy4, pnt4); end
  endtask

  task automatic test_wrap();
    apply_reset();
    bus3.out_ready = 1'b1; bus3.req_valid = 3'b010; bus3.req_last = 3'b111;
    cyc(); cyc(); #1;
    checks++; if (pnt3 !== 2'd2) begin errors++; $display("FAIL wrap_pnt_pre got %0d exp 2", pnt3); end
    bus3.req_valid = 3'b100;
    cyc(); #1;
    checks++; if (bus3.out_id !== 2'd2 || bus3.req_ready !== 3'b100) begin errors++; $display("FAIL wrap_grant got id %0d ready %b exp 2 100", bus3.out_id, bus3.req_ready); end
    cyc(); #1;
    checks++; if (pnt3 !== 2'd0 || busy3 !== 1'b0) begin errors++; $display("FAIL wrap_pnt got %0d busy %b exp 0 0", pnt3, busy3); end
    bus3.req_valid = 3'b000;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    bus4.req_valid = 4'b1000; bus4.req_last = 4'b0000; bus4.out_ready = 1'b1;
    bus4.req_data[3*32 +: 32] = 32'h400;
    cyc();
    for (int b = 0; b < 2; b++) begin
      bus4.req_data[3*32 +: 32] = 32'h400 + b; #1;
      checks++; if (bus4.out_data !== 32'h400 + 32'(b) || bus4.req_ready !== 4'b1000) begin errors++; $display("FAIL midrst_beat got data %h ready %b exp %h 1000", bus4.out_data, bus4.req_ready, 32'h400 + 32'(b)); end
      cyc();
    end
    rst = 1'b1; bus4.req_valid = 4'b1010;
    cyc(); #1;
    checks++; if (busy4 !== 1'b0 || bus4.out_valid !== 1'b0 || pnt4 !== 2'd0) begin errors++; $display("FAIL midrst_state got busy %b valid %b pnt %0d exp 0 0 0", busy4, bus4.out_valid, pnt4); end
    checks++; if (bus4.req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready got %b exp 0000", bus4.req_ready); end
    rst = 1'b0;
    cyc(); #1;
    checks++; if (bus4.out_id !== 2'd1 || busy4 !== 1'b1) begin errors++; $display("FAIL midrst_regrant got id %0d busy %b exp 1 1", bus4.out_id, busy4); end
  endtask

  initial begin
    rst = 1'b1;
    bus4.req_valid = '0; bus4.req_last = '0; bus4.req_data = '0; bus4.out_ready = 1'b0;
    bus3.req_valid = '0; bus3.req_last = '0; bus3.req_data = '0; bus3.out_ready = 1'b0;
    #2;
    test_reset();
    test_rotation();
    test_burst_lock();
    test_gap();
    test_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
